// File: rtl/fb_pkg.sv
// Shared constants, clear-FSM state type and pixel address helper for the
// plot_framebuffer frame store.
package fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = 15;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_FILL = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    // Row-major pixel address; w defaults to the package frame width.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x,
                                                 input logic [6:0] y,
                                                 input int         w = FB_W);
        fb_addr = FB_AW'(int'(y) * w + int'(x));
    endfunction

endpackage

// File: rtl/plot_framebuffer_if.sv
// Pixel write stream from the drawing engines into plot_framebuffer.
interface plot_framebuffer_if;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (output vga_x, output vga_y, output vga_colour, output vga_plot);
    modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  vga_plot);

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port frame store: one write port, one registered read port,
// read-before-write on address collision.
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    // Both accesses are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/plot_framebuffer.sv
// Frame store for the drawing engines: plot write stream, start/done bulk
// clear and raster read-out. FB_OOB_COUNT_EN enables the dropped-plot counter.
//
// state    | meaning
// CLR_IDLE | no clear in progress, plot stream owns the write port
// CLR_FILL | writing clear_colour at clr_addr, one pixel per cycle
// CLR_DONE | frame filled, clear_done held until clear_start drops
module plot_framebuffer #(
    parameter int FB_W = fb_pkg::FB_W,
    parameter int FB_H = fb_pkg::FB_H
) (
    input  logic                clk,
    input  logic                rst_n,
    plot_framebuffer_if.slave   plot,
    input  logic                clear_start,
    input  logic [2:0]          clear_colour,
    output logic                clear_done,
    input  logic                scan_en,
    output logic [7:0]          pix_x,
    output logic [6:0]          pix_y,
    output logic [2:0]          pix_colour,
    output logic                pix_valid,
    output logic                frame_start,
    output logic [15:0]         oob_count
);

    import fb_pkg::*;

    localparam int DEPTH = FB_W * FB_H;
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(DEPTH - 1);

    clr_state_t       state;
    logic [FB_AW-1:0] clr_addr;
    logic             in_bounds;
    logic             we;
    logic [FB_AW-1:0] wa;
    logic [2:0]       wd;
    logic [7:0]       sx;
    logic [6:0]       sy;
    logic [2:0]       rd_data;

    assign in_bounds = (plot.vga_x < 8'(FB_W)) && (plot.vga_y < 7'(FB_H));

    // Clear owns the port while filling; plots in that window are lost.
    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        if (state == CLR_FILL) begin
            we = 1'b1;
            wa = clr_addr;
            wd = clear_colour;
        end else if (plot.vga_plot && in_bounds) begin
            we = 1'b1;
            wa = fb_addr(plot.vga_x, plot.vga_y, FB_W);
            wd = plot.vga_colour;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLR_IDLE;
            clr_addr   <= '0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    clr_addr <= '0;
                    if (clear_start) begin
                        state <= CLR_FILL;
                    end
                end
                CLR_FILL: begin
                    if (clr_addr == LAST_ADDR) begin
                        if (clear_start) begin
                            state      <= CLR_DONE;
                            clear_done <= 1'b1;
                        end else begin
                            state <= CLR_IDLE;
                        end
                    end else if (!clear_start) begin
                        state <= CLR_IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                CLR_DONE: begin
                    if (!clear_start) begin
                        state      <= CLR_IDLE;
                        clear_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= CLR_IDLE;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx          <= '0;
            sy          <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= scan_en;
            frame_start <= scan_en && (sx == '0) && (sy == '0);
            if (scan_en) begin
                pix_x <= sx;
                pix_y <= sy;
                if (sx == 8'(FB_W - 1)) begin
                    sx <= '0;
                    sy <= (sy == 7'(FB_H - 1)) ? '0 : sy + 1'b1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end
        end
    end

    fb_ram #(
        .DEPTH (DEPTH),
        .AW    (FB_AW),
        .DW    (3)
    ) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (wd),
        .re  (scan_en),
        .ra  (fb_addr(sx, sy, FB_W)),
        .rd  (rd_data)
    );

    // The RAM output register has no reset; mask it so idle read-out is 0.
    assign pix_colour = pix_valid ? rd_data : 3'b000;

`ifdef FB_OOB_COUNT_EN
    logic [15:0] oob_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_q <= '0;
        end else if ((state != CLR_FILL) && plot.vga_plot && !in_bounds &&
                     (oob_q != 16'hFFFF)) begin
            oob_q <= oob_q + 16'd1;
        end
    end

    assign oob_count = oob_q;
`else
    assign oob_count = 16'd0;
`endif

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed self-checking bench for plot_framebuffer.
module tb_plot_framebuffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_start = 1'b0;
    logic [2:0]  clear_colour = 3'b000;
    logic        clear_done;
    logic        scan_en = 1'b0;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  pix_colour;
    logic        pix_valid;
    logic        frame_start;
    logic [15:0] oob_count;

    int errors = 0;
    int checks = 0;
    int m_x = 0, m_y = 0;
    int exp_x = 0, exp_y = 0;

    plot_framebuffer_if pif ();

    plot_framebuffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .plot         (pif.slave),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .scan_en      (scan_en),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_colour   (pix_colour),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start),
        .oob_count    (oob_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        scan_en = 1'b0;
        clear_start = 1'b0;
        pif.vga_plot = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_x = 0;
        m_y = 0;
    endtask

    // One read-out cycle; exp_x/exp_y become the pixel now on pix_*.
    task automatic scan_step;
        scan_en = 1'b1;
        tick();
        exp_x = m_x;
        exp_y = m_y;
        m_x++;
        if (m_x == 160) begin
            m_x = 0;
            m_y++;
            if (m_y == 120) m_y = 0;
        end
    endtask

    task automatic plot_px(input int x, input int y, input logic [2:0] c);
        pif.vga_x = 8'(x);
        pif.vga_y = 7'(y);
        pif.vga_colour = c;
        pif.vga_plot = 1'b1;
        tick();
        pif.vga_plot = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({clear_done, pix_x, pix_y, pix_colour, pix_valid, frame_start, oob_count} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%0d x=%0d y=%0d c=%0d v=%0d fs=%0d oob=%0d required all 0",
                     clear_done, pix_x, pix_y, pix_colour, pix_valid, frame_start, oob_count);
        end
        do_reset();
        checks++;
        if (pix_valid !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got valid=%0d done=%0d required 0 0", pix_valid, clear_done);
        end
    endtask

    task automatic test_plot_scan;
        do_reset();
        plot_px(5, 7, 3'b101);
        repeat (1126) scan_step();
        checks++;
        if (pix_x !== 8'd5 || pix_y !== 7'd7 || pix_colour !== 3'b101 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL plot_scan: got x=%0d y=%0d c=%b v=%0d required x=5 y=7 c=101 v=1",
                     pix_x, pix_y, pix_colour, pix_valid);
        end
    endtask

    task automatic test_oob;
        logic [15:0] exp_oob;
`ifdef FB_OOB_COUNT_EN
        exp_oob = 16'd2;
`else
        exp_oob = 16'd0;
`endif
        do_reset();
        plot_px(0, 1, 3'b110);
        plot_px(160, 0, 3'b001);
        plot_px(0, 120, 3'b001);
        checks++;
        if (oob_count !== exp_oob) begin
            errors++;
            $display("FAIL oob_count: got %0d required %0d", oob_count, exp_oob);
        end
        repeat (161) scan_step();
        checks++;
        if (pix_x !== 8'd0 || pix_y !== 7'd1 || pix_colour !== 3'b110) begin
            errors++;
            $display("FAIL oob_no_write: got x=%0d y=%0d c=%b required x=0 y=1 c=110",
                     pix_x, pix_y, pix_colour);
        end
    endtask

    task automatic test_collision;
        do_reset();
        plot_px(2, 0, 3'b011);
        scan_step();
        scan_step();
        pif.vga_x = 8'd2;
        pif.vga_y = 7'd0;
        pif.vga_colour = 3'b110;
        pif.vga_plot = 1'b1;
        scan_step();
        pif.vga_plot = 1'b0;
        checks++;
        if (pix_x !== 8'd2 || pix_colour !== 3'b011) begin
            errors++;
            $display("FAIL collision_old_data: got x=%0d c=%b required x=2 c=011", pix_x, pix_colour);
        end
        do_reset();
        repeat (3) scan_step();
        checks++;
        if (pix_colour !== 3'b110) begin
            errors++;
            $display("FAIL collision_write_kept: got c=%b required 110", pix_colour);
        end
    endtask

    task automatic test_scan_hold;
        do_reset();
        repeat (160) scan_step();
        checks++;
        if (pix_x !== 8'd159 || pix_y !== 7'd0 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_at_159: got x=%0d y=%0d v=%0d required x=159 y=0 v=1",
                     pix_x, pix_y, pix_valid);
        end
        scan_en = 1'b0;
        tick();
        checks++;
        if (pix_valid !== 1'b0 || pix_x !== 8'd159 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL hold_low1: got v=%0d x=%0d fs=%0d required v=0 x=159 fs=0",
                     pix_valid, pix_x, frame_start);
        end
        tick();
        checks++;
        if (pix_valid !== 1'b0 || pix_x !== 8'd159 || pix_y !== 7'd0) begin
            errors++;
            $display("FAIL hold_low2: got v=%0d x=%0d y=%0d required v=0 x=159 y=0",
                     pix_valid, pix_x, pix_y);
        end
        scan_step();
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== 8'd0 || pix_y !== 7'd1) begin
            errors++;
            $display("FAIL hold_resume: got v=%0d x=%0d y=%0d required v=1 x=0 y=1",
                     pix_valid, pix_x, pix_y);
        end
    endtask

    task automatic test_clear;
        int done_edge;
        int bad;
        int fs;
        logic [2:0] c11;
        done_edge = 0;
        bad = 0;
        fs = 0;
        c11 = 3'b000;
        do_reset();
        clear_colour = 3'b010;
        clear_start = 1'b1;
        for (int n = 1; n <= 25000; n++) begin
            if (n == 1000) begin
                pif.vga_x = 8'd1;
                pif.vga_y = 7'd1;
                pif.vga_colour = 3'b111;
                pif.vga_plot = 1'b1;
            end
            tick();
            pif.vga_plot = 1'b0;
            if (clear_done === 1'b1) begin
                done_edge = n;
                break;
            end
        end
        checks++;
        if (done_edge != 19201) begin
            errors++;
            $display("FAIL clear_length: got edge %0d required 19201 (0 = timeout)", done_edge);
        end
        repeat (3) tick();
        checks++;
        if (clear_done !== 1'b1) begin
            errors++;
            $display("FAIL clear_done_held: got %0d required 1", clear_done);
        end
        clear_start = 1'b0;
        tick();
        checks++;
        if (clear_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_fall: got %0d required 0", clear_done);
        end
        do_reset();
        for (int i = 0; i < 19200; i++) begin
            scan_step();
            if (pix_colour !== 3'b010 || pix_valid !== 1'b1 ||
                pix_x !== 8'(exp_x) || pix_y !== 7'(exp_y)) bad++;
            if (frame_start === 1'b1) fs++;
            if (exp_x == 1 && exp_y == 1) c11 = pix_colour;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_full_scan: got %0d bad pixels required 0", bad);
        end
        checks++;
        if (fs != 1) begin
            errors++;
            $display("FAIL frame_start_count: got %0d required 1", fs);
        end
        checks++;
        if (c11 !== 3'b010) begin
            errors++;
            $display("FAIL plot_during_clear: got c=%b at (1,1) required 010", c11);
        end
        scan_step();
        checks++;
        if (frame_start !== 1'b1 || pix_x !== 8'd0 || pix_y !== 7'd0) begin
            errors++;
            $display("FAIL frame_wrap: got fs=%0d x=%0d y=%0d required fs=1 x=0 y=0",
                     frame_start, pix_x, pix_y);
        end
    endtask

    task automatic test_clear_abort;
        int cd_seen;
        int bad;
        logic [2:0] c101;
        cd_seen = 0;
        bad = 0;
        c101 = 3'b000;
        do_reset();
        clear_colour = 3'b100;
        clear_start = 1'b1;
        tick();
        repeat (100) begin
            tick();
            if (clear_done !== 1'b0) cd_seen++;
        end
        clear_start = 1'b0;
        repeat (5) begin
            tick();
            if (clear_done !== 1'b0) cd_seen++;
        end
        checks++;
        if (cd_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d cycles with done required 0", cd_seen);
        end
        do_reset();
        for (int i = 0; i < 102; i++) begin
            scan_step();
            if (i < 100 && pix_colour !== 3'b100) bad++;
            if (i == 101) c101 = pix_colour;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_partial_fill: got %0d bad pixels in 0..99 required 0", bad);
        end
        checks++;
        if (c101 !== 3'b010) begin
            errors++;
            $display("FAIL abort_stopped: got c=%b at addr 101 required 010", c101);
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [2:0] c10;
        logic [2:0] c60;
        c10 = 3'b000;
        c60 = 3'b000;
        do_reset();
        clear_colour = 3'b001;
        clear_start = 1'b1;
        scan_en = 1'b1;
        repeat (50) tick();
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: got %0d required 1", pix_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({clear_done, pix_x, pix_y, pix_colour, pix_valid, frame_start, oob_count} !== 37'd0) begin
            errors++;
            $display("FAIL async_reset: got done=%0d x=%0d y=%0d c=%0d v=%0d fs=%0d oob=%0d required all 0",
                     clear_done, pix_x, pix_y, pix_colour, pix_valid, frame_start, oob_count);
        end
        clear_start = 1'b0;
        scan_en = 1'b0;
        tick();
        rst_n = 1'b1;
        m_x = 0;
        m_y = 0;
        for (int i = 0; i < 61; i++) begin
            scan_step();
            if (i == 10) c10 = pix_colour;
            if (i == 60) c60 = pix_colour;
        end
        checks++;
        if (c10 !== 3'b001 || c60 !== 3'b100) begin
            errors++;
            $display("FAIL reset_partial_fill: got addr10=%b addr60=%b required 001 100", c10, c60);
        end
        checks++;
        if (clear_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resume: got done=%0d required 0", clear_done);
        end
    endtask

    initial begin
        pif.vga_x = 8'd0;
        pif.vga_y = 7'd0;
        pif.vga_colour = 3'b000;
        pif.vga_plot = 1'b0;
        test_reset();
        test_plot_scan();
        test_oob();
        test_collision();
        test_scan_hold();
        test_clear();
        test_clear_abort();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
